sine_root: RTL and testbench

//  Iterative integer NUM-th root extractor: root = floor(x_pow^(1/NUM)).

---
 rtl/sine_root_pkg.sv | 24 ++
 rtl/sine_root_pow_iter.sv | 47 ++++
 rtl/sine_root.sv | 138 +++++++++++++
 tb/tb_sine_root.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/sine_root_pkg.sv
// Shared definitions for the sine_root integer root extractor.
//   state_t   : FSM state encoding (3 bits, IDLE..DONE)
//   NUM_MIN/NUM_MAX : legal range for the root degree
//   CNT_W     : width of the power-iteration counter (covers NUM-1 up to 6)
//   ceil_div  : integer ceiling division, used to check the root width
package sine_root_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TRIAL = 3'd1,
        ST_POW   = 3'd2,
        ST_CMP   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int NUM_MIN = 2;
    localparam int NUM_MAX = 7;
    localparam int CNT_W   = 3;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/sine_root_pow_iter.sv
// Power iterator for sine_root: raises a candidate to the NUM-th power with
// one multiplier reused over NUM-1 cycles.
// Ports:
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   load     : acc <= cand, cnt <= NUM-1
//   step     : acc <= acc*cand, cnt <= cnt-1
//   cand     : candidate root, held stable by the caller while stepping
//   acc      : running power, NUM*BITS_O bits wide
//   last     : this step is the final multiplication (cnt == 1)
module sine_root_pow_iter
    import sine_root_pkg::*;
#(
    parameter int BITS_O = 7,
    parameter int NUM    = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic                    step,
    input  logic [BITS_O-1:0]       cand,
    output logic [NUM*BITS_O-1:0]   acc,
    output logic                    last
);

    localparam int AW = NUM * BITS_O;

    logic [CNT_W-1:0] cnt;
    logic [AW-1:0]    cand_ext;

    // cand^k < 2^(k*BITS_O), so keeping AW bits of the product never loses data.
    assign cand_ext = {{(AW-BITS_O){1'b0}}, cand};
    assign last     = (cnt == CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
        end else if (load) begin
            acc <= cand_ext;
            cnt <= CNT_W'(NUM - 1);
        end else if (step) begin
            acc <= acc * cand_ext;
            cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/sine_root.sv
// sine_root: iterative integer NUM-th root, root = floor(x_pow^(1/NUM)).
// Restoring MSB-first search: each result bit is tried by raising the trial
// candidate to the NUM-th power and comparing against the radicand.
// Handshake: a request is accepted on a rising edge where vld=1 and rdy=1;
// rdy is high only in IDLE, vld is ignored otherwise, and x_pow is sampled
// only on the accepting edge. Completion is a one-cycle root_vld pulse; root
// and exact hold their values until the next completion.
// Ports:
//   clk, rst  : clock (rising edge), asynchronous active-high reset
//   vld       : request
//   x_pow     : radicand, unsigned BITS_I bits
//   rdy       : idle, can accept
//   root      : result, BITS_O bits
//   root_vld  : completion pulse
//   exact     : root^NUM == x_pow
//   state_dbg : current FSM state, for observation
module sine_root
    import sine_root_pkg::*;
#(
    parameter int BITS_I = 21,
    parameter int NUM    = 3,
    parameter int BITS_O = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vld,
    input  logic [BITS_I-1:0] x_pow,
    output logic              rdy,
    output logic [BITS_O-1:0] root,
    output logic              root_vld,
    output logic              exact,
    output logic [2:0]        state_dbg
);

    localparam int AW = NUM * BITS_O;
    localparam int IW = (BITS_O > 1) ? $clog2(BITS_O) : 1;

    if (NUM < NUM_MIN || NUM > NUM_MAX) begin : g_bad_num
        $error("sine_root: NUM must be in 2..7");
    end
    if (BITS_O < ceil_div(BITS_I, NUM)) begin : g_bad_bits_o
        $error("sine_root: BITS_O must be >= ceil(BITS_I/NUM)");
    end

    state_t            state, state_nxt;
    logic [BITS_I-1:0] rad;
    logic [BITS_O-1:0] res;
    logic [IW-1:0]     idx;
    logic              ex;
    logic [BITS_O-1:0] cand;
    logic [AW-1:0]     acc;
    logic [AW-1:0]     rad_ext;
    logic              pow_load;
    logic              pow_step;
    logic              pow_last;

    // res and idx only change in CMP, so cand is stable through TRIAL/POW/CMP.
    assign cand    = res | (BITS_O'(1) << idx);
    assign rad_ext = AW'(rad);

    sine_root_pow_iter #(
        .BITS_O (BITS_O),
        .NUM    (NUM)
    ) u_pow (
        .clk  (clk),
        .rst  (rst),
        .load (pow_load),
        .step (pow_step),
        .cand (cand),
        .acc  (acc),
        .last (pow_last)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (vld) state_nxt = ST_TRIAL;
            ST_TRIAL: state_nxt = ST_POW;
            ST_POW:   if (pow_last) state_nxt = ST_CMP;
            ST_CMP:   state_nxt = (idx == '0) ? ST_DONE : ST_TRIAL;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        rdy       = (state == ST_IDLE);
        pow_load  = (state == ST_TRIAL);
        pow_step  = (state == ST_POW);
        state_dbg = state;
    end

    // Search registers and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rad      <= '0;
            res      <= '0;
            idx      <= '0;
            ex       <= 1'b0;
            root     <= '0;
            exact    <= 1'b0;
            root_vld <= 1'b0;
        end else begin
            root_vld <= (state == ST_DONE);
            case (state)
                ST_IDLE: begin
                    if (vld) begin
                        rad <= x_pow;
                        res <= '0;
                        idx <= IW'(BITS_O - 1);
                        // A zero radicand never equals any nonzero trial power,
                        // yet 0^NUM == 0, so it is exact from the start.
                        ex  <= (x_pow == '0);
                    end
                end
                ST_CMP: begin
                    if (acc <= rad_ext) res <= cand;
                    if (acc == rad_ext) ex  <= 1'b1;
                    if (idx != '0)      idx <= idx - IW'(1);
                end
                ST_DONE: begin
                    root  <= res;
                    exact <= ex;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sine_root.sv
// Directed bench for sine_root: a NUM=3/BITS_O=7 instance and a
// NUM=5/BITS_O=5 instance share clock and reset.
module tb_sine_root;

    logic        clk = 1'b0;
    logic        rst;

    logic        vld3;
    logic [20:0] x3;
    logic        rdy3, rv3, ex3;
    logic [6:0]  root3;
    logic [2:0]  st3;

    logic        vld5;
    logic [20:0] x5;
    logic        rdy5, rv5, ex5;
    logic [4:0]  root5;
    logic [2:0]  st5;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    sine_root #(.BITS_I(21), .NUM(3), .BITS_O(7)) u_dut3 (
        .clk(clk), .rst(rst), .vld(vld3), .x_pow(x3), .rdy(rdy3),
        .root(root3), .root_vld(rv3), .exact(ex3), .state_dbg(st3)
    );

    sine_root #(.BITS_I(21), .NUM(5), .BITS_O(5)) u_dut5 (
        .clk(clk), .rst(rst), .vld(vld5), .x_pow(x5), .rdy(rdy5),
        .root(root5), .root_vld(rv5), .exact(ex5), .state_dbg(st5)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pop the oldest expected {exact, root} and compare with the completion.
    task automatic score(input string tag, input logic [7:0] obs);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_unexpected"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_sb"}, {24'd0, obs}, {24'd0, e});
        end
    endtask

    // ---------------- drivers ----------------
    // One request to the selected instance (3 or 5); checks result, exact,
    // latency, rdy at completion and that root_vld is a single pulse.
    task automatic run_op(input int sel, input logic [20:0] x, input int exp_root,
                          input logic exp_ex, input int exp_lat, input string tag);
        int n;
        logic r_v, r_rdy, r_ex;
        logic [6:0] r_root;
        @(negedge clk);
        if (sel == 3) begin vld3 = 1'b1; x3 = x; end
        else          begin vld5 = 1'b1; x5 = x; end
        @(posedge clk); #1;
        // x_pow is a don't-care after the accepting edge.
        vld3 = 1'b0; vld5 = 1'b0;
        if (sel == 3) x3 = 21'($urandom); else x5 = 21'($urandom);
        exp_q.push_back({exp_ex, exp_root[6:0]});
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            r_v = (sel == 3) ? rv3 : rv5;
        end while (!r_v && n < 200);
        r_rdy  = (sel == 3) ? rdy3 : rdy5;
        r_ex   = (sel == 3) ? ex3 : ex5;
        r_root = (sel == 3) ? root3 : {2'b00, root5};
        check({tag, "_vld"},   {31'd0, r_v},   32'd1);
        check({tag, "_root"},  {25'd0, r_root}, exp_root);
        check({tag, "_exact"}, {31'd0, r_ex},  {31'd0, exp_ex});
        check({tag, "_lat"},   n, exp_lat);
        check({tag, "_rdy"},   {31'd0, r_rdy}, 32'd1);
        score(tag, {r_ex, r_root});
        @(posedge clk); #1;
        r_v = (sel == 3) ? rv3 : rv5;
        check({tag, "_pulse"}, {31'd0, r_v}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n, pulses;
        logic rdy_ok;

        rst = 1'b1; vld3 = 1'b0; vld5 = 1'b0; x3 = '0; x5 = '0;
        #1;
        check("rst_rdy",   {31'd0, rdy3}, 32'd1);
        check("rst_root",  {25'd0, root3}, 32'd0);
        check("rst_vld",   {31'd0, rv3}, 32'd0);
        check("rst_exact", {31'd0, ex3}, 32'd0);
        check("rst_state", {29'd0, st3}, 32'd0);
        check("rst_rdy5",  {31'd0, rdy5}, 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;

        // Basic cube roots and boundaries.
        run_op(3, 21'd27,      3,   1'b1, 29, "cube27");
        run_op(3, 21'd26,      2,   1'b0, 29, "cube26");
        run_op(3, 21'd0,       0,   1'b1, 29, "cube0");
        run_op(3, 21'd2097151, 127, 1'b0, 29, "cube_max");
        run_op(3, 21'd1,       1,   1'b1, 29, "cube1");
        run_op(3, 21'd2048383, 127, 1'b1, 29, "cube127");

        // vld while busy must be ignored.
        @(negedge clk); vld3 = 1'b1; x3 = 21'd64;
        @(posedge clk); #1; vld3 = 1'b0; x3 = 21'd0;
        n = 0; rdy_ok = 1'b1;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 4) begin vld3 = 1'b1; x3 = 21'd8; end
            else        begin vld3 = 1'b0; end
            if (!rv3 && rdy3) rdy_ok = 1'b0;
        end while (!rv3 && n < 200);
        vld3 = 1'b0;
        check("busy_root",    {25'd0, root3}, 32'd4);
        check("busy_exact",   {31'd0, ex3}, 32'd1);
        check("busy_lat",     n, 29);
        check("busy_rdy_low", {31'd0, rdy_ok}, 32'd1);
        pulses = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (rv3) pulses++;
        end
        check("busy_no_second", pulses, 0);
        check("busy_root_held", {25'd0, root3}, 32'd4);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk); vld3 = 1'b1; x3 = 21'd125;
        @(posedge clk); #1; vld3 = 1'b0;
        repeat (10) @(posedge clk);
        #3; rst = 1'b1;
        #1;
        check("abort_root",  {25'd0, root3}, 32'd0);
        check("abort_exact", {31'd0, ex3}, 32'd0);
        check("abort_vld",   {31'd0, rv3}, 32'd0);
        check("abort_rdy",   {31'd0, rdy3}, 32'd1);
        check("abort_state", {29'd0, st3}, 32'd0);
        @(posedge clk);
        @(negedge clk); rst = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (rv3) pulses++;
        end
        check("abort_no_pulse", pulses, 0);
        run_op(3, 21'd1000, 10, 1'b1, 29, "after_abort");

        // Fifth roots on the second instance.
        run_op(5, 21'd3125,    5,  1'b1, 31, "fifth3125");
        run_op(5, 21'd3124,    4,  1'b0, 31, "fifth3124");
        run_op(5, 21'd2097151, 18, 1'b0, 31, "fifth_max");
        run_op(5, 21'd0,       0,  1'b1, 31, "fifth0");

        check("sb_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
